// File: rtl/rd_req_generator_pkg.sv
// Shared types, default widths and width helpers for the read-request generator.
package rd_req_generator_pkg;

    localparam int DEFAULT_ADDR_WIDTH      = 58;
    localparam int DEFAULT_USER_TAG_WIDTH  = 8;
    localparam int DEFAULT_LEN_WIDTH       = 32;
    localparam int DEFAULT_MAX_OUTSTANDING = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    // Bits needed to hold every value from 0 up to and including max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/rd_credit_counter.sv
// Outstanding-line counter: counts issued-but-unconsumed lines and flags when
// another request may be issued without exceeding the limit.
module rd_credit_counter
    import rd_req_generator_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int CNT_WIDTH       = cnt_width(MAX_OUTSTANDING)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic credit_avail
);

    logic [CNT_WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   count <= count + CNT_WIDTH'(1);
                // A stray response with nothing outstanding must not wrap the count.
                2'b01:   if (count != '0) count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    assign credit_avail = (count < CNT_WIDTH'(MAX_OUTSTANDING));

endmodule

// File: rtl/rd_req_generator.sv
// Command-driven read-request generator: expands (base, line count) into one
// tagged request per cache line, throttled by outstanding-line credits.
module rd_req_generator
    import rd_req_generator_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int USER_TAG_WIDTH  = DEFAULT_USER_TAG_WIDTH,
    parameter int LEN_WIDTH       = DEFAULT_LEN_WIDTH,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_num_lines,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic [ADDR_WIDTH-1:0]     usr_tx_rd_addr,
    output logic [USER_TAG_WIDTH-1:0] usr_tx_rd_tag,
    output logic                      usr_tx_rd_valid,
    input  logic                      usr_tx_rd_free,
    input  logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic                      done,
    output logic [LEN_WIDTH-1:0]      lines_issued
);

    localparam int CNT_WIDTH = cnt_width(MAX_OUTSTANDING);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  num_lines;
    logic [LEN_WIDTH-1:0]  line_idx;
    logic [LEN_WIDTH-1:0]  consumed;
    logic                  credit_avail;
    logic                  rd_fire;
    logic                  rsp_fire;

    // Responses seen while no command is active belong to nothing and are dropped.
    assign rsp_fire = rsp_valid & rsp_ready & busy;
    assign rd_fire  = (state == ISSUE) & usr_tx_rd_free & credit_avail;

    assign usr_tx_rd_valid = rd_fire;
    assign usr_tx_rd_addr  = base_addr + ADDR_WIDTH'(line_idx);
    assign usr_tx_rd_tag   = line_idx[USER_TAG_WIDTH-1:0];
    assign lines_issued    = line_idx;

    rd_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_credit (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc          (rd_fire),
        .dec          (rsp_fire),
        .credit_avail (credit_avail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_addr <= '0;
            num_lines <= '0;
            line_idx  <= '0;
            consumed  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            if (rsp_fire) begin
                consumed <= consumed + LEN_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base_addr <= cmd_addr;
                        num_lines <= cmd_num_lines;
                        line_idx  <= '0;
                        consumed  <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        // An empty command skips straight to completion.
                        state     <= (cmd_num_lines == '0) ? DRAIN : ISSUE;
                    end
                end

                ISSUE: begin
                    if (rd_fire) begin
                        line_idx <= line_idx + LEN_WIDTH'(1);
                        if (line_idx == num_lines - LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (consumed == num_lines) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_req_generator.sv
// Directed bench for rd_req_generator with a 4-line outstanding limit and a
// simple delayed-response downstream model.
module tb_rd_req_generator;

    localparam int ADDR_WIDTH     = 58;
    localparam int USER_TAG_WIDTH = 8;
    localparam int LEN_WIDTH      = 32;
    localparam int MAX_OUT        = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [LEN_WIDTH-1:0]      cmd_num_lines;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_WIDTH-1:0]     usr_tx_rd_addr;
    logic [USER_TAG_WIDTH-1:0] usr_tx_rd_tag;
    logic                      usr_tx_rd_valid;
    logic                      usr_tx_rd_free;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      busy;
    logic                      done;
    logic [LEN_WIDTH-1:0]      lines_issued;

    always #5 clk = ~clk;

    rd_req_generator #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .USER_TAG_WIDTH  (USER_TAG_WIDTH),
        .LEN_WIDTH       (LEN_WIDTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_addr        (cmd_addr),
        .cmd_num_lines   (cmd_num_lines),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .usr_tx_rd_addr  (usr_tx_rd_addr),
        .usr_tx_rd_tag   (usr_tx_rd_tag),
        .usr_tx_rd_valid (usr_tx_rd_valid),
        .usr_tx_rd_free  (usr_tx_rd_free),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .busy            (busy),
        .done            (done),
        .lines_issued    (lines_issued)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   auto_on = 1'b0;
    bit   bp_on = 1'b0;
    int   bp_base = 0;
    int   accept_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   bad_valid = 0;
    logic done_busy = 1'b0;
    logic done_ready = 1'b0;
    int   rsp_cyc = 0;

    int                        rsp_due[$];
    logic [ADDR_WIDTH-1:0]     log_addr[$];
    logic [USER_TAG_WIDTH-1:0] log_tag[$];
    int                        log_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rsp_due.delete();
        log_addr.delete();
        log_tag.delete();
        log_cyc.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        bad_valid = 0;
        auto_on   = 1'b0;
        bp_on     = 1'b0;
    endtask

    // One clock: inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
    task automatic step(input logic free_i, input logic rsp_i);
        logic rsp;
        @(posedge clk);
        #1;
        cyc++;
        cmd_valid      = 1'b0;
        usr_tx_rd_free = bp_on ? logic'((cyc - bp_base) % 3 == 0) : free_i;
        rsp = rsp_i;
        if (auto_on && rsp_due.size() != 0 && rsp_due[0] <= cyc) begin
            rsp = 1'b1;
            void'(rsp_due.pop_front());
        end
        rsp_valid = rsp;
        rsp_ready = rsp;
        #1;
        if (usr_tx_rd_valid === 1'b1) begin
            if (usr_tx_rd_free !== 1'b1) bad_valid++;
            log_addr.push_back(usr_tx_rd_addr);
            log_tag.push_back(usr_tx_rd_tag);
            log_cyc.push_back(cyc);
            if (auto_on) rsp_due.push_back(cyc + 3);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc   = cyc;
            done_busy  = busy;
            done_ready = cmd_ready;
        end
    endtask

    task automatic send_cmd(input logic [ADDR_WIDTH-1:0] a, input logic [LEN_WIDTH-1:0] n);
        cmd_addr      = a;
        cmd_num_lines = n;
        cmd_valid     = 1'b1;
        bp_base       = cyc + 1;
        step(1'b1, 1'b0);
        accept_cyc = cyc;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step(1'b1, 1'b0);
            n++;
        end
    endtask

    logic [ADDR_WIDTH-1:0] wrap_exp [4];

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_addr       = '0;
        cmd_num_lines  = '0;
        usr_tx_rd_free = 1'b0;
        rsp_valid      = 1'b0;
        rsp_ready      = 1'b0;
        wrap_exp[0]    = 58'h3FF_FFFF_FFFF_FFFE;
        wrap_exp[1]    = 58'h3FF_FFFF_FFFF_FFFF;
        wrap_exp[2]    = 58'h0;
        wrap_exp[3]    = 58'h1;

        #12;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_lines_issued", 64'(lines_issued), 64'd0);
        check("reset_valid", 64'(usr_tx_rd_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic: 4 lines at 0x100, responses 3 cycles after each issue.
        clear_logs();
        auto_on = 1'b1;
        send_cmd(58'h100, 32'd4);
        check("basic_accept_busy", 64'(busy), 64'd1);
        check("basic_accept_ready", 64'(cmd_ready), 64'd0);
        run_until_done(40);
        repeat (3) step(1'b1, 1'b0);
        check("basic_issues", 64'(log_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) begin
                check("basic_addr", 64'(log_addr[i]), 64'h100 + 64'(i));
                check("basic_tag", 64'(log_tag[i]), 64'(i));
                check("basic_cycle", 64'(log_cyc[i]), 64'(accept_cyc + i));
            end
        end
        check("basic_done_count", 64'(done_cnt), 64'd1);
        check("basic_done_cycle", 64'(done_cyc), 64'(accept_cyc + 8));
        check("basic_done_busy", 64'(done_busy), 64'd0);
        check("basic_done_ready", 64'(done_ready), 64'd1);
        check("basic_lines_issued", 64'(lines_issued), 64'd4);

        // Zero-length command completes the cycle after accept with no requests.
        clear_logs();
        send_cmd(58'h55, 32'd0);
        run_until_done(10);
        repeat (2) step(1'b1, 1'b0);
        check("zero_issues", 64'(log_addr.size()), 64'd0);
        check("zero_done_count", 64'(done_cnt), 64'd1);
        check("zero_done_cycle", 64'(done_cyc), 64'(accept_cyc + 1));
        check("zero_lines_issued", 64'(lines_issued), 64'd0);

        // Credit limit: no responses, only 4 lines may be outstanding.
        clear_logs();
        send_cmd(58'h2000, 32'd10);
        repeat (7) step(1'b1, 1'b0);
        check("credit_stall_issues", 64'(log_addr.size()), 64'd4);
        step(1'b1, 1'b1);
        rsp_cyc = cyc;
        step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        check("credit_one_more", 64'(log_addr.size()), 64'd5);
        if (log_cyc.size() > 4) check("credit_refill_cycle", 64'(log_cyc[4]), 64'(rsp_cyc + 1));
        repeat (4) rsp_due.push_back(cyc);
        auto_on = 1'b1;
        run_until_done(80);
        repeat (2) step(1'b1, 1'b0);
        check("credit_total_issues", 64'(log_addr.size()), 64'd10);
        if (log_addr.size() > 9) check("credit_last_addr", 64'(log_addr[9]), 64'h2009);
        check("credit_done_count", 64'(done_cnt), 64'd1);
        check("credit_lines_issued", 64'(lines_issued), 64'd10);

        // Backpressure: free follows 1,0,0 repeating from the accept cycle.
        clear_logs();
        auto_on = 1'b1;
        bp_on   = 1'b1;
        send_cmd(58'h200, 32'd6);
        run_until_done(80);
        bp_on = 1'b0;
        repeat (2) step(1'b1, 1'b0);
        check("bp_valid_without_free", 64'(bad_valid), 64'd0);
        check("bp_issues", 64'(log_addr.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_addr.size()) begin
                check("bp_addr", 64'(log_addr[i]), 64'h200 + 64'(i));
                check("bp_cycle", 64'(log_cyc[i]), 64'(accept_cyc + 3 * i));
            end
        end
        check("bp_done_count", 64'(done_cnt), 64'd1);

        // Address wrap at the top of the address space.
        clear_logs();
        auto_on = 1'b1;
        send_cmd(58'h3FF_FFFF_FFFF_FFFE, 32'd4);
        run_until_done(40);
        repeat (2) step(1'b1, 1'b0);
        check("wrap_issues", 64'(log_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) check("wrap_addr", 64'(log_addr[i]), 64'(wrap_exp[i]));
        end
        check("wrap_done_count", 64'(done_cnt), 64'd1);

        // Tag wrap over a 300-line command at full throughput.
        clear_logs();
        auto_on = 1'b1;
        send_cmd(58'h1000, 32'd300);
        run_until_done(400);
        repeat (2) step(1'b1, 1'b0);
        check("tagwrap_issues", 64'(log_addr.size()), 64'd300);
        if (log_tag.size() == 300) begin
            check("tagwrap_tag255", 64'(log_tag[255]), 64'd255);
            check("tagwrap_tag256", 64'(log_tag[256]), 64'd0);
            check("tagwrap_tag299", 64'(log_tag[299]), 64'd43);
            check("tagwrap_addr299", 64'(log_addr[299]), 64'h112B);
            check("tagwrap_cycle299", 64'(log_cyc[299]), 64'(accept_cyc + 299));
        end
        check("tagwrap_done_count", 64'(done_cnt), 64'd1);
        check("tagwrap_lines_issued", 64'(lines_issued), 64'd300);

        // Reset in ISSUE with 3 lines outstanding, then stray responses.
        clear_logs();
        send_cmd(58'h300, 32'd10);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("midrst_pre_valid", 64'(usr_tx_rd_valid), 64'd1);
        check("midrst_pre_lines", 64'(lines_issued), 64'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_lines_issued", 64'(lines_issued), 64'd0);
        check("midrst_valid", 64'(usr_tx_rd_valid), 64'd0);
        repeat (2) step(1'b1, 1'b1);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        check("midrst_no_done", 64'(done_cnt), 64'd0);

        // Fresh command after reset must see a full set of credits.
        clear_logs();
        send_cmd(58'h400, 32'd6);
        repeat (5) step(1'b1, 1'b0);
        check("postrst_credit_issues", 64'(log_addr.size()), 64'd4);
        repeat (4) rsp_due.push_back(cyc);
        auto_on = 1'b1;
        run_until_done(60);
        repeat (2) step(1'b1, 1'b0);
        check("postrst_issues", 64'(log_addr.size()), 64'd6);
        if (log_addr.size() > 5) check("postrst_last_addr", 64'(log_addr[5]), 64'h405);
        check("postrst_done_count", 64'(done_cnt), 64'd1);
        check("postrst_lines_issued", 64'(lines_issued), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
